// File: rtl/m_series_sync.sv
// Chip-rate synchroniser for the x^5+x^2+1 m-sequence: fills, verifies, then flywheels a local replica.
// Optional macro M_SERIES_SYNC_STATS_EN adds a saturating err_total counter of chip errors seen in LOCK.
module m_series_sync #(
  parameter int VERIFY_LEN  = 31,
  parameter int LOSS_THRESH = 4
) (
  input  logic        clk_1m,
  input  logic        rst,
  input  logic        chip_in,
  input  logic        chip_valid,
  output logic        locked,
  output logic        chip_ref,
  output logic        ref_valid,
  output logic        chip_err,
  output logic        despread
`ifdef M_SERIES_SYNC_STATS_EN
  ,
  output logic [15:0] err_total
`endif
);

  localparam logic [7:0] VLEN = 8'(VERIFY_LEN);
  localparam logic [3:0] LTHR = 4'(LOSS_THRESH);

  typedef enum logic [1:0] {FILL, VERIFY, LOCK} state_t;

  state_t     state, state_next;
  logic [4:0] hist, hist_next;
  logic [2:0] fill_cnt, fill_cnt_next;
  logic [7:0] match_cnt, match_cnt_next;
  logic [3:0] miss_cnt, miss_cnt_next;
  logic       pred;
  logic       ref_bit;
  logic       err_bit;

  // b(n) = b(n-2) xor b(n-5), with hist[0] the newest chip
  assign pred   = hist[1] ^ hist[4];
  assign locked = (state == LOCK);

  always_comb begin
    state_next     = state;
    hist_next      = hist;
    fill_cnt_next  = fill_cnt;
    match_cnt_next = match_cnt;
    miss_cnt_next  = miss_cnt;
    ref_bit        = chip_in;
    err_bit        = 1'b0;
    if (chip_valid) begin
      case (state)
        FILL: begin
          hist_next = {hist[3:0], chip_in};
          if (fill_cnt == 3'd4) begin
            state_next     = VERIFY;
            fill_cnt_next  = 3'd0;
            match_cnt_next = 8'd0;
          end else begin
            fill_cnt_next = fill_cnt + 3'd1;
          end
        end
        VERIFY: begin
          ref_bit   = pred;
          err_bit   = chip_in ^ pred;
          hist_next = {hist[3:0], chip_in};
          match_cnt_next = err_bit ? 8'd0 : match_cnt + 8'd1;
          // An all-zero history is the lock-up state of the LFSR; start over.
          if (hist_next == 5'b00000) begin
            state_next    = FILL;
            fill_cnt_next = 3'd0;
          end else if (!err_bit && match_cnt_next == VLEN) begin
            state_next    = LOCK;
            miss_cnt_next = 4'd0;
          end
        end
        LOCK: begin
          ref_bit   = pred;
          err_bit   = chip_in ^ pred;
          hist_next = {hist[3:0], pred};
          if (err_bit) begin
            miss_cnt_next = miss_cnt + 4'd1;
          end else if (miss_cnt != 4'd0) begin
            miss_cnt_next = miss_cnt - 4'd1;
          end
          if (err_bit && miss_cnt_next == LTHR) begin
            state_next    = FILL;
            fill_cnt_next = 3'd0;
          end
        end
        default: begin
          state_next    = FILL;
          fill_cnt_next = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      hist      <= 5'b00000;
      fill_cnt  <= 3'd0;
      match_cnt <= 8'd0;
      miss_cnt  <= 4'd0;
      chip_ref  <= 1'b0;
      ref_valid <= 1'b0;
      chip_err  <= 1'b0;
      despread  <= 1'b0;
    end else begin
      state     <= state_next;
      hist      <= hist_next;
      fill_cnt  <= fill_cnt_next;
      match_cnt <= match_cnt_next;
      miss_cnt  <= miss_cnt_next;
      ref_valid <= chip_valid;
      if (chip_valid) begin
        chip_ref <= ref_bit;
        chip_err <= err_bit;
        despread <= chip_in ^ ref_bit;
      end
    end
  end

`ifdef M_SERIES_SYNC_STATS_EN
  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      err_total <= 16'd0;
    end else if (chip_valid && state == LOCK && err_bit && err_total != 16'hFFFF) begin
      err_total <= err_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_series_sync.sv
// Self-checking bench for m_series_sync: vector table, directed lock/loss/reset sequences and
// randomized traffic against a queue-based model of the m-sequence synchroniser.
module tb_m_series_sync;

  localparam int VERIFY_LEN  = 31;
  localparam int LOSS_THRESH = 4;

  logic clk_1m = 1'b0;
  logic rst = 1'b1;
  logic chip_in = 1'b0;
  logic chip_valid = 1'b0;
  logic locked, chip_ref, ref_valid, chip_err, despread;
`ifdef M_SERIES_SYNC_STATS_EN
  logic [15:0] err_total;
`endif

  m_series_sync #(.VERIFY_LEN(VERIFY_LEN), .LOSS_THRESH(LOSS_THRESH)) dut (
    .clk_1m    (clk_1m),
    .rst       (rst),
    .chip_in   (chip_in),
    .chip_valid(chip_valid),
    .locked    (locked),
    .chip_ref  (chip_ref),
    .ref_valid (ref_valid),
    .chip_err  (chip_err),
    .despread  (despread)
`ifdef M_SERIES_SYNC_STATS_EN
    ,
    .err_total (err_total)
`endif
  );

  always #5 clk_1m = ~clk_1m;

  int checks = 0;
  int errors = 0;

  // Reference model: last five chips as a queue, q[4] newest, q[0] oldest.
  bit q[$];
  int m_mode;   // 0 = fill, 1 = verify, 2 = lock
  int m_fill, m_run, m_loss, m_errtot;
  bit e_rv, e_ref, e_err, e_desp, e_locked;

  bit seq[31];
  int pos;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit next_clean();
    next_clean = seq[pos % 31];
    pos++;
  endfunction

  task automatic model_reset();
    q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    m_mode = 0; m_fill = 0; m_run = 0; m_loss = 0; m_errtot = 0;
    e_rv = 0; e_ref = 0; e_err = 0; e_desp = 0; e_locked = 0;
  endtask

  task automatic model_shift(input bit b);
    q.push_back(b);
    void'(q.pop_front());
  endtask

  task automatic model_step(input bit v, input bit c);
    bit p;
    int ones;
    e_rv = v;
    if (v) begin
      p = q[3] ^ q[0];
      if (m_mode == 0) begin
        model_shift(c);
        e_ref = c; e_err = 0;
        m_fill++;
        if (m_fill == 5) begin m_mode = 1; m_run = 0; m_fill = 0; end
      end else if (m_mode == 1) begin
        e_ref = p; e_err = c ^ p;
        model_shift(c);
        m_run = e_err ? 0 : m_run + 1;
        ones = 0;
        foreach (q[i]) ones += int'(q[i]);
        if (ones == 0) begin m_mode = 0; m_fill = 0; end
        else if (m_run == VERIFY_LEN) begin m_mode = 2; m_loss = 0; end
      end else begin
        e_ref = p; e_err = c ^ p;
        model_shift(p);
        if (e_err) begin
          m_loss++;
          if (m_errtot < 65535) m_errtot++;
        end else if (m_loss > 0) begin
          m_loss--;
        end
        if (m_loss == LOSS_THRESH) begin m_mode = 0; m_fill = 0; end
      end
      e_desp = c ^ e_ref;
    end
    e_locked = (m_mode == 2);
  endtask

  task automatic step(input bit v, input bit c);
    chip_valid = v;
    chip_in = c;
    @(posedge clk_1m);
    model_step(v, c);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ref_valid"}, ref_valid, e_rv);
    chk({tag, ".locked"}, locked, e_locked);
    if (e_rv) begin
      chk({tag, ".chip_ref"}, chip_ref, e_ref);
      chk({tag, ".chip_err"}, chip_err, e_err);
      chk({tag, ".despread"}, despread, e_desp);
    end
`ifdef M_SERIES_SYNC_STATS_EN
    chk_int({tag, ".err_total"}, int'(err_total), m_errtot);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    chip_valid = 1'b0;
    chip_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_1m);
    #1 rst = 1'b0;
    pos = 0;
  endtask

  typedef struct {
    bit v; bit c; bit e_rv; bit e_ref; bit e_err; bit e_locked;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int lock_at, burst;
    bit c, cc;

    seq[0] = 1; seq[1] = 1; seq[2] = 1; seq[3] = 1; seq[4] = 1;
    for (int n = 5; n < 31; n++) seq[n] = seq[n-2] ^ seq[n-5];

    // Fill with 1,0,(idle),1,1,0 then two verify chips whose predictions follow the recurrence.
    tbl[0] = '{1, 1, 1, 1, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 1, 1, 0, 0};
    tbl[4] = '{1, 1, 1, 1, 0, 0};
    tbl[5] = '{1, 0, 1, 0, 0, 0};
    tbl[6] = '{1, 1, 1, 0, 1, 0};
    tbl[7] = '{1, 0, 1, 0, 0, 0};

    do_reset();
    chk("reset.locked", locked, 1'b0);
    chk("reset.ref_valid", ref_valid, 1'b0);
    chk("reset.chip_ref", chip_ref, 1'b0);
    chk("reset.chip_err", chip_err, 1'b0);
    chk("reset.despread", despread, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].c);
      chk("tbl.ref_valid", ref_valid, tbl[i].e_rv);
      chk("tbl.locked", locked, tbl[i].e_locked);
      if (tbl[i].v) begin
        chk("tbl.chip_ref", chip_ref, tbl[i].e_ref);
        chk("tbl.chip_err", chip_err, tbl[i].e_err);
        chk("tbl.despread", despread, tbl[i].c ^ tbl[i].e_ref);
      end
    end

    // Clean lock from seed 5'h1F: locked rises on the 36th valid chip.
    do_reset();
    lock_at = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, next_clean());
      check_model("clean");
      if (locked && lock_at == 0) lock_at = i;
    end
    chk_int("clean.lock_chip", lock_at, 36);

    // Single flipped chip while locked.
    c = next_clean();
    step(1'b1, ~c);
    check_model("flip1");
    chk("flip1.chip_err", chip_err, 1'b1);
    chk("flip1.despread", despread, 1'b1);
    chk("flip1.locked", locked, 1'b1);
    c = next_clean();
    step(1'b1, c);
    check_model("after_flip1");
    chk("after_flip1.chip_ref", chip_ref, c);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, next_clean());
      check_model("settle");
    end

    // Four consecutive errors drop lock on the fourth; clean input re-locks after 36 chips.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, ~next_clean());
      check_model("flip4");
      chk("flip4.locked", locked, (i < 4) ? 1'b1 : 1'b0);
    end
    lock_at = 0;
    for (int i = 1; i <= 50; i++) begin
      step(1'b1, next_clean());
      check_model("relock");
      if (locked && lock_at == 0) lock_at = i;
    end
    chk_int("relock.lock_chip", lock_at, 36);

    // All-zero stream never locks.
    do_reset();
    lock_at = 0;
    for (int i = 0; i < 120; i++) begin
      step(1'b1, 1'b0);
      check_model("zeros");
      if (locked) lock_at = 1;
    end
    chk_int("zeros.never_locked", lock_at, 0);

    // Alternating valid, starting idle: lock on clock 72.
    do_reset();
    lock_at = 0;
    for (int i = 1; i <= 90; i++) begin
      if ((i % 2) == 0) step(1'b1, next_clean());
      else step(1'b0, 1'b0);
      check_model("toggle");
      if (locked && lock_at == 0) lock_at = i;
    end
    chk_int("toggle.lock_clock", lock_at, 72);

    // Asynchronous reset while locked clears outputs before the next edge.
    step(1'b1, next_clean());
    check_model("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("midrst.locked", locked, 1'b0);
    chk("midrst.ref_valid", ref_valid, 1'b0);
    chk("midrst.chip_ref", chip_ref, 1'b0);
    chk("midrst.chip_err", chip_err, 1'b0);
    chk("midrst.despread", despread, 1'b0);
`ifdef M_SERIES_SYNC_STATS_EN
    chk_int("midrst.err_total", int'(err_total), 0);
`endif
    do_reset();
    lock_at = 0;
    for (int i = 1; i <= 45; i++) begin
      step(1'b1, next_clean());
      check_model("post_rst");
      if (locked && lock_at == 0) lock_at = i;
    end
    chk_int("post_rst.lock_chip", lock_at, 36);

    // Randomized traffic: gappy valid, error bursts of 1..5 chips.
    do_reset();
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) != 0) begin
        if (burst == 0 && $urandom_range(59) == 0) burst = 1 + $urandom_range(4);
        cc = next_clean();
        step(1'b1, cc ^ (burst > 0));
        if (burst > 0) burst--;
      end else begin
        step(1'b0, 1'($urandom_range(1)));
      end
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_series_sync.md
M_SERIES_SYNC -- requirements
Module: m_series_sync

Interface
REQ-001 SHALL have parameter VERIFY_LEN, default 31, meaning consecutive correct chip predictions needed to declare lock (range 1..255).
REQ-002 SHALL have parameter LOSS_THRESH, default 4, meaning the leaky mismatch-counter value that declares loss of lock (range 1..15).
REQ-003 SHALL have port clk_1m  input  1  chip-rate system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port chip_in  input  1  received chip of the x^5+x^2+1 m-sequence (period 31).
REQ-006 SHALL have port chip_valid  input  1  qualifies chip_in; the block SHALL ignore chip_in when low.
REQ-007 SHALL have port locked  output  1  high while in state LOCK.
REQ-008 SHALL have port chip_ref  output  1  regenerated local replica chip for the current valid input.
REQ-009 SHALL have port ref_valid  output  1  one-cycle pulse marking chip_ref and chip_err valid.
REQ-010 SHALL have port chip_err  output  1  high with ref_valid when chip_in differed from the prediction.
REQ-011 SHALL have port despread  output  1  chip_in XOR chip_ref, valid with ref_valid.

Function
REQ-012 SHALL hold a 5-chip history hist[4:0], hist[0] = newest chip, hist[4] = oldest.
REQ-013 SHALL predict each next chip as hist[1] XOR hist[4], i.e. b(n) = b(n-2) XOR b(n-5).
REQ-014 SHALL implement states FILL, VERIFY, LOCK; FILL is the reset state.
REQ-015 In FILL, each valid chip SHALL shift chip_in into hist; after the 5th valid chip the state SHALL go to VERIFY with match counter cleared.
REQ-016 In VERIFY, each valid chip SHALL be compared with the prediction and SHALL shift chip_in into hist; match increments the counter; mismatch clears it and stays in VERIFY.
REQ-017 In VERIFY, if hist is all-zero after an update, the state SHALL return to FILL with the fill count cleared.
REQ-018 When the match counter reaches VERIFY_LEN, the state SHALL go to LOCK on that same edge, with the mismatch counter cleared.
REQ-019 In LOCK, hist SHALL shift in the predicted chip (flywheel), not chip_in, so isolated input errors never corrupt the replica.
REQ-020 In LOCK, the 4-bit mismatch counter SHALL increment on mismatch and decrement on match, saturating at 0.
REQ-021 When the mismatch counter reaches LOSS_THRESH, the state SHALL go to FILL, locked SHALL fall on the same edge, and hist SHALL be kept.
REQ-022 ref_valid, chip_ref, chip_err and despread SHALL be registered and SHALL appear one clock after the valid input chip, in every state.
REQ-023 chip_ref SHALL equal the prediction in VERIFY and LOCK, and chip_in in FILL, where chip_err SHALL be 0.
REQ-024 Back-to-back valid chips (chip_valid held high) SHALL be processed at one chip per clock with no gaps.

Reset
REQ-025 Reset SHALL force state FILL, hist = 5'b00000, all counters to 0, and locked, chip_ref, ref_valid, chip_err and despread to 0.
REQ-026 Reset asserted mid-operation, including in LOCK, SHALL take effect immediately and SHALL discard all history.

Configuration
REQ-027 With macro M_SERIES_SYNC_STATS_EN defined, the block SHALL add output err_total (16 bits), counting chip_err pulses in LOCK, saturating at 16'hFFFF, and cleared by reset only.
REQ-028 Without M_SERIES_SYNC_STATS_EN, the err_total port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-029 Reset release, then a continuous clean sequence from seed 5'h1F: locked SHALL rise on the edge of the 5+31 = 36th valid chip; chip_ref SHALL match chip_in thereafter with chip_err = 0.
REQ-030 Once locked, a single flipped chip: one chip_err pulse, despread = 1 for that chip, locked stays high, and the next chip_ref SHALL still be correct.
REQ-031 Once locked, 4 consecutive flipped chips (LOSS_THRESH = 4): locked SHALL fall on the 4th error; after clean input resumes, it SHALL re-lock after 36 more valid chips.
REQ-032 An all-zero input stream SHALL never assert locked, and the state SHALL cycle FILL -> VERIFY -> FILL.
REQ-033 chip_valid toggling 1-0-1-0 with a clean sequence: lock after 36 valid chips (72 clocks), and ref_valid pulses SHALL track valid chips only.
REQ-034 rst pulsed while locked: all outputs 0 within the same cycle; with M_SERIES_SYNC_STATS_EN, err_total = 0 after reset and saturates at 16'hFFFF under a continuous inverted input forced in LOCK.
